// File: rtl/ip_arb_pkg.sv
// Shared definitions for the IP-frame arbiter/demux family:
// FSM state encoding, header field widths and the packed header record.
package ip_arb_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PAYLOAD = 1'b1
  } arb_state_e;

  localparam int DSCP_W  = 6;
  localparam int ECN_W   = 2;
  localparam int LEN_W   = 16;
  localparam int TTL_W   = 8;
  localparam int PROTO_W = 8;
  localparam int IP_W    = 32;

  typedef struct packed {
    logic [DSCP_W-1:0]  dscp;
    logic [ECN_W-1:0]   ecn;
    logic [LEN_W-1:0]   length;
    logic [TTL_W-1:0]   ttl;
    logic [PROTO_W-1:0] protocol;
    logic [IP_W-1:0]    source_ip;
    logic [IP_W-1:0]    dest_ip;
    logic               is_roce;
  } ip_hdr_t;

endpackage

// File: rtl/ip_rr_select.sv
// Round-robin requester pick: first asserted request at or after ptr_i,
// wrapping modulo S_COUNT. Purely combinational.
module ip_rr_select #(
  parameter int S_COUNT = 2,
  parameter int IW      = $clog2(S_COUNT)
) (
  input  logic [S_COUNT-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [S_COUNT-1:0] onehot_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_req_o
);

  logic found;
  int   j;

  always_comb begin
    onehot_o  = '0;
    idx_o     = '0;
    any_req_o = |req_i;
    found     = 1'b0;
    j         = 0;
    for (int i = 0; i < S_COUNT; i++) begin
      j = (int'(ptr_i) + i) % S_COUNT;
      if (!found && req_i[j]) begin
        found       = 1'b1;
        idx_o       = IW'(j);
        onehot_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ip_tx_arb_64.sv
// Frame-locked round-robin arbiter in front of the IP block transmit port:
// registers the winner's header, then passes its payload through until tlast.
module ip_tx_arb_64
  import ip_arb_pkg::*;
#(
  parameter int S_COUNT    = 2,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int GW         = $clog2(S_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT-1:0]            s_ip_hdr_valid,
  output logic [S_COUNT-1:0]            s_ip_hdr_ready,
  input  logic [S_COUNT*DSCP_W-1:0]     s_ip_dscp,
  input  logic [S_COUNT*ECN_W-1:0]      s_ip_ecn,
  input  logic [S_COUNT*LEN_W-1:0]      s_ip_length,
  input  logic [S_COUNT*TTL_W-1:0]      s_ip_ttl,
  input  logic [S_COUNT*PROTO_W-1:0]    s_ip_protocol,
  input  logic [S_COUNT*IP_W-1:0]       s_ip_source_ip,
  input  logic [S_COUNT*IP_W-1:0]       s_ip_dest_ip,
  input  logic [S_COUNT-1:0]            s_is_roce_packet,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_ip_payload_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_ip_payload_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_ip_payload_axis_tvalid,
  input  logic [S_COUNT-1:0]            s_ip_payload_axis_tlast,
  input  logic [S_COUNT-1:0]            s_ip_payload_axis_tuser,
  output logic [S_COUNT-1:0]            s_ip_payload_axis_tready,
  output logic                          m_ip_hdr_valid,
  input  logic                          m_ip_hdr_ready,
  output logic [DSCP_W-1:0]             m_ip_dscp,
  output logic [ECN_W-1:0]              m_ip_ecn,
  output logic [LEN_W-1:0]              m_ip_length,
  output logic [TTL_W-1:0]              m_ip_ttl,
  output logic [PROTO_W-1:0]            m_ip_protocol,
  output logic [IP_W-1:0]               m_ip_source_ip,
  output logic [IP_W-1:0]               m_ip_dest_ip,
  output logic                          m_is_roce_packet,
  output logic [DATA_WIDTH-1:0]         m_ip_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_ip_payload_axis_tkeep,
  output logic                          m_ip_payload_axis_tvalid,
  output logic                          m_ip_payload_axis_tlast,
  output logic                          m_ip_payload_axis_tuser,
  input  logic                          m_ip_payload_axis_tready,
  output logic [GW-1:0]                 grant,
  output logic                          busy
);

  arb_state_e         state_q, state_d;
  logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic               hdr_valid_q, hdr_valid_d;
  ip_hdr_t            hdr_q;
  logic [S_COUNT-1:0] sel_oh;
  logic [GW-1:0]      sel_idx;
  logic               any_req;
  logic               accept;
  logic               frame_end;

  ip_rr_select #(.S_COUNT(S_COUNT), .IW(GW)) u_rr_select (
    .req_i     (s_ip_hdr_valid),
    .ptr_i     (rr_ptr_q),
    .onehot_o  (sel_oh),
    .idx_o     (sel_idx),
    .any_req_o (any_req)
  );

  // A header still pending downstream blocks the next acceptance.
  assign accept    = (state_q == ST_IDLE) && any_req && !hdr_valid_q;
  assign frame_end = (state_q == ST_PAYLOAD) && m_ip_payload_axis_tvalid &&
                     m_ip_payload_axis_tready && m_ip_payload_axis_tlast;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept)    state_d = ST_PAYLOAD;
      ST_PAYLOAD: if (frame_end) state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ip_hdr_ready           = accept ? sel_oh : '0;
    s_ip_payload_axis_tready = '0;
    m_ip_payload_axis_tvalid = 1'b0;
    m_ip_payload_axis_tdata  = '0;
    m_ip_payload_axis_tkeep  = '0;
    m_ip_payload_axis_tlast  = 1'b0;
    m_ip_payload_axis_tuser  = 1'b0;
    if (state_q == ST_PAYLOAD) begin
      m_ip_payload_axis_tvalid = s_ip_payload_axis_tvalid[grant_q];
      m_ip_payload_axis_tdata  = s_ip_payload_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
      m_ip_payload_axis_tkeep  = s_ip_payload_axis_tkeep[int'(grant_q)*KEEP_WIDTH +: KEEP_WIDTH];
      m_ip_payload_axis_tlast  = s_ip_payload_axis_tlast[grant_q];
      m_ip_payload_axis_tuser  = s_ip_payload_axis_tuser[grant_q];
      s_ip_payload_axis_tready[grant_q] = m_ip_payload_axis_tready;
    end
  end

  always_comb begin
    grant_d     = accept ? sel_idx : grant_q;
    hdr_valid_d = accept ? 1'b1 : (m_ip_hdr_ready ? 1'b0 : hdr_valid_q);
    rr_ptr_d    = rr_ptr_q;
    if (frame_end)
      rr_ptr_d = (grant_q == GW'(S_COUNT-1)) ? '0 : grant_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      hdr_valid_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      hdr_valid_q <= hdr_valid_d;
    end
  end

  // Header fields carry no reset; they are qualified by m_ip_hdr_valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      hdr_q.dscp      <= s_ip_dscp[int'(sel_idx)*DSCP_W +: DSCP_W];
      hdr_q.ecn       <= s_ip_ecn[int'(sel_idx)*ECN_W +: ECN_W];
      hdr_q.length    <= s_ip_length[int'(sel_idx)*LEN_W +: LEN_W];
      hdr_q.ttl       <= s_ip_ttl[int'(sel_idx)*TTL_W +: TTL_W];
      hdr_q.protocol  <= s_ip_protocol[int'(sel_idx)*PROTO_W +: PROTO_W];
      hdr_q.source_ip <= s_ip_source_ip[int'(sel_idx)*IP_W +: IP_W];
      hdr_q.dest_ip   <= s_ip_dest_ip[int'(sel_idx)*IP_W +: IP_W];
      hdr_q.is_roce   <= s_is_roce_packet[sel_idx];
    end
  end

  assign m_ip_hdr_valid   = hdr_valid_q;
  assign m_ip_dscp        = hdr_q.dscp;
  assign m_ip_ecn         = hdr_q.ecn;
  assign m_ip_length      = hdr_q.length;
  assign m_ip_ttl         = hdr_q.ttl;
  assign m_ip_protocol    = hdr_q.protocol;
  assign m_ip_source_ip   = hdr_q.source_ip;
  assign m_ip_dest_ip     = hdr_q.dest_ip;
  assign m_is_roce_packet = hdr_q.is_roce;
  assign grant            = grant_q;
  assign busy             = (state_q == ST_PAYLOAD);

endmodule
